// File: rtl/ls_unit_if.sv
// Memory and CDB handshake bundle for ls_unit; the unit drives it through the master modport.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

interface ls_unit_if;
    logic                    mem_req;
    logic                    mem_we;
    logic [`XLEN-1:0]        mem_addr;
    logic [`XLEN-1:0]        mem_wdata;
    logic [3:0]              mem_be;
    logic                    mem_ack;
    logic [`XLEN-1:0]        mem_rdata;
    logic                    cdb_valid;
    logic [`ROB_TAG_LEN-1:0] cdb_rob_tag;
    logic [`XLEN-1:0]        cdb_data;
    logic                    cdb_grant;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata,
        output cdb_valid, cdb_rob_tag, cdb_data,
        input  cdb_grant
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata,
        input  cdb_valid, cdb_rob_tag, cdb_data,
        output cdb_grant
    );
endinterface

// File: rtl/ls_unit.sv
// Single-entry load/store unit: address generation, one memory access, CDB writeback.
// Optional misalignment trap enabled by defining LS_UNIT_MISALIGN_CHECK_EN.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package ls_unit_pkg;
    typedef enum logic [1:0] {
        LS_LOAD  = 2'd0,
        LS_LOADU = 2'd1,
        LS_STORE = 2'd2
    } ls_func_e;

    typedef struct packed {
        logic [`XLEN-1:0]        value_src1;
        logic [`XLEN-1:0]        value_src2;
        logic [`XLEN-1:0]        imm;
        logic [`ROB_TAG_LEN-1:0] insn_tag;
        ls_func_e                func;
        logic [2:0]              funct3;
        logic                    read_write;
    } LS_UNIT_PACK;
endpackage

module ls_unit
    import ls_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          valid_in,
    input  LS_UNIT_PACK   insn_in,
    output logic          fu_reg_empty,
    output logic          done,
    output logic          ls_exception,
    ls_unit_if.master     bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        MEM,
        DRAIN,
        WB
    } state_e;

    state_e            state_q, state_d;
    LS_UNIT_PACK       insn_q, insn_d;
    logic [`XLEN-1:0]  addr_q, addr_d;
    logic [`XLEN-1:0]  result_q, result_d;

    logic [1:0]        lane;
    logic [1:0]        size;
    logic              is_load;
    logic              misaligned;
    logic              in_mem;
    logic [3:0]        be_base;
    logic [`XLEN-1:0]  load_word;
    logic [`XLEN-1:0]  load_val;
    logic              unused_funct3;

    assign lane          = addr_q[1:0];
    assign size          = insn_q.funct3[1:0];
    assign is_load       = insn_q.read_write;
    assign unused_funct3 = insn_q.funct3[2];

`ifdef LS_UNIT_MISALIGN_CHECK_EN
    assign misaligned   = ((size == 2'b01) && lane[0]) || (size[1] && (lane != 2'b00));
    assign ls_exception = (state_q == MEM) && misaligned && done;
`else
    assign misaligned   = 1'b0;
    assign ls_exception = 1'b0;
`endif

    // A trapped access never reaches the bus; DRAIN keeps the squashed load's request up.
    assign in_mem = ((state_q == MEM) && !misaligned) || (state_q == DRAIN);

    always_comb begin
        be_base = 4'b1111;
        case (size)
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
    end

    assign load_word = bus.mem_rdata >> {lane, 3'b000};

    always_comb begin
        load_val = load_word;
        case (size)
            2'b00: load_val = {{(`XLEN-8){(insn_q.func == LS_LOAD) && load_word[7]}}, load_word[7:0]};
            2'b01: load_val = {{(`XLEN-16){(insn_q.func == LS_LOAD) && load_word[15]}}, load_word[15:0]};
            default: load_val = load_word;
        endcase
    end

    assign fu_reg_empty    = (state_q == IDLE);
    assign bus.mem_req     = in_mem;
    assign bus.mem_we      = in_mem && !is_load;
    assign bus.mem_addr    = in_mem ? {addr_q[`XLEN-1:2], 2'b00} : '0;
    assign bus.mem_be      = in_mem ? 4'(be_base << lane) : 4'b0000;
    assign bus.mem_wdata   = (in_mem && !is_load) ? (insn_q.value_src2 << {lane, 3'b000}) : '0;
    assign bus.cdb_valid   = (state_q == WB);
    assign bus.cdb_rob_tag = (state_q == WB) ? insn_q.insn_tag : '0;
    assign bus.cdb_data    = (state_q == WB) ? result_q : '0;

    // Stores are already committed when they reach MEM, so flush only squashes loads there.
    always_comb begin
        state_d  = state_q;
        insn_d   = insn_q;
        addr_d   = addr_q;
        result_d = result_q;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in && !flush) begin
                    insn_d  = insn_in;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    addr_d  = insn_q.value_src1 + insn_q.imm;
                    state_d = MEM;
                end
            end
            MEM: begin
                if (misaligned) begin
                    done    = !(flush && is_load);
                    state_d = IDLE;
                end else if (bus.mem_ack) begin
                    if (!is_load) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else if (flush) begin
                        state_d = IDLE;
                    end else begin
                        result_d = load_val;
                        state_d  = WB;
                    end
                end else if (flush && is_load) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_ack) begin
                    state_d = IDLE;
                end
            end
            WB: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (bus.cdb_grant) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            insn_q   <= '0;
            addr_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            insn_q   <= insn_d;
            addr_q   <= addr_d;
            result_q <= result_d;
        end
    end

endmodule

// File: doc/ls_unit.md
LS_UNIT -- requirements
Module: ls_unit

Interface
REQ-001 Parameter: none; widths come from sys_defs.svh (`XLEN, `ROB_TAG_LEN) and ls_queue.svh (LS_UNIT_PACK).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high; sampled on posedge clk.
REQ-004 flush  input  1  synchronous squash of speculative work (branch mispredict).
REQ-005 valid_in  input  1  queue offers an insn (driven by queue to_ls_unit).
REQ-006 insn_in  input  LS_UNIT_PACK  insn (value_src1, value_src2, imm, insn_tag, func, funct3) and read_write (1=load, 0=store).
REQ-007 fu_reg_empty  output  1  unit can accept an insn this cycle.
REQ-008 done  output  1  one-cycle pulse, current insn retired from unit (to queue done_from_ls_unit).
REQ-009 mem_req, mem_we  output  1 each  memory request valid; write enable.
REQ-010 mem_addr, mem_wdata  output  `XLEN each  word-aligned address; lane-shifted store data.
REQ-011 mem_be  output  4  byte enables.
REQ-012 mem_ack  input  1  memory completes current request this cycle; mem_rdata  input  `XLEN  read word, valid with mem_ack.
REQ-013 cdb_valid  output  1; cdb_rob_tag  output  `ROB_TAG_LEN; cdb_data  output  `XLEN  load result broadcast.
REQ-014 cdb_grant  input  1  CDB arbiter accepts broadcast this cycle.
REQ-015 ls_exception  output  1  misaligned access flag, valid with done.

Function
REQ-016 FSM states: IDLE, ADDR, MEM, DRAIN, WB; fu_reg_empty SHALL equal (state==IDLE).
REQ-017 IDLE: valid_in && !flush SHALL latch insn_in and go to ADDR; otherwise stay.
REQ-018 ADDR: register addr = value_src1 + imm, modulo 2^`XLEN (carry dropped); go to MEM next cycle.
REQ-019 MEM: mem_req=1, mem_addr={addr[`XLEN-1:2],2'b00}, mem_we=!read_write; hold all request outputs stable until mem_ack.
REQ-020 Size from funct3[1:0]: 00 byte, 01 half, 10 word; mem_be = 0001/0011/1111 shifted left by addr[1:0]; store data shifted left by 8*addr[1:0].
REQ-021 Store: on mem_ack, done pulses the same cycle, go IDLE; no CDB broadcast.
REQ-022 Load: on mem_ack, extract lane addr[1:0]; LS_LOAD sign-extends, LS_LOADU zero-extends to `XLEN; register result, go WB.
REQ-023 WB: cdb_valid=1 with insn_tag and result held stable until cdb_grant; on cdb_grant, done pulses that cycle, go IDLE.
REQ-024 Minimum latency: load accept at cycle 0, mem_ack at cycle 2, cdb_grant at cycle 3 -> done at cycle 3; store with ack at cycle 2 -> done at cycle 2.
REQ-025 Flush in ADDR or WB: go IDLE next cycle, no done, no cdb_valid afterwards.
REQ-026 Flush in MEM for load, no mem_ack: go DRAIN, keep mem_req until mem_ack, then IDLE, no done, no CDB; flush with mem_ack same cycle: go IDLE.
REQ-027 Flush in MEM for store: ignored (committed store); store completes normally with done.
REQ-028 DRAIN: ignores valid_in and further flush; fu_reg_empty=0.
REQ-029 done, cdb_valid, mem_req never asserted in IDLE; at most one insn in flight.

Reset
REQ-030 reset SHALL force state=IDLE, fu_reg_empty=1, done=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, cdb_valid=0, cdb_rob_tag=0, cdb_data=0, ls_exception=0.
REQ-031 reset mid-operation (any state, incl. MEM) SHALL abandon the access immediately with no done and no CDB.
REQ-032 reset has priority over flush and valid_in in the same cycle.

Configuration
REQ-033 Macro LS_UNIT_MISALIGN_CHECK_EN: when defined, half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip MEM, pulse done with ls_exception=1 one cycle after ADDR, and return IDLE with no CDB broadcast.
REQ-034 When undefined, ls_exception SHALL be tied 0 and misaligned accesses are issued, with out-of-word lanes dropped by byte enables.

Verification
REQ-035 Load word value_src1=0x1000, imm=4, tag=5; mem_ack cycle 2 with rdata=0xDEADBEEF; grant cycle 3 -> mem_addr=0x1004, be=1111, cdb 5/0xDEADBEEF, done cycle 3.
REQ-036 Store byte addr 0x2003, value_src2=0xAB -> mem_we=1, be=1000, wdata=0xAB000000; done on ack; no cdb_valid.
REQ-037 LS_LOAD byte addr 0x3001, rdata=0x00008000 -> cdb_data=0xFFFFFF80; LS_LOADU same -> 0x00000080.
REQ-038 Load, flush in MEM, ack delayed 3 cycles -> DRAIN holds mem_req, then IDLE; no done, no cdb_valid; fu_reg_empty=1 after ack.
REQ-039 cdb_grant held low 4 cycles in WB -> cdb outputs stable; valid_in ignored (fu_reg_empty=0) until done.
REQ-040 Macro defined, word load addr 0x1002 -> no mem_req, done+ls_exception=1 at cycle 2; macro undefined -> request with be=1100.
